// File: rtl/crop_ctrl_pkg.sv
// crop_ctrl_pkg: shared definitions for the crop configuration controller.
// The dtype width and codes mirror the shared dtypes.v of the image pipeline;
// no new codes are introduced here. Pixel beats are any code with the top
// bit set (the pixel-format family in dtypes.v).
package crop_ctrl_pkg;

  localparam int unsigned DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MONO  = 4'h8;

  localparam int unsigned DEF_DIM_WIDTH       = 12;
  localparam int unsigned DEF_FRAME_CNT_WIDTH = 16;

  // True for any pixel-carrying dtype code.
  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
    return dt[DTYPE_WIDTH-1];
  endfunction

endpackage

// File: rtl/crop_ctrl_if.sv
// crop_ctrl_if: stream observation, register-side config request and
// status/active-config outputs of crop_ctrl.
//   master: register terminal / stream source (drives dvi, dtypei, cfg_*)
//   slave : crop_ctrl (drives enable, num_output_*, status)
interface crop_ctrl_if #(
  parameter int unsigned DIM_WIDTH       = 12,
  parameter int unsigned FRAME_CNT_WIDTH = 16
);
  import crop_ctrl_pkg::*;

  logic                       dvi;
  logic [DTYPE_WIDTH-1:0]     dtypei;
  logic                       cfg_req;
  logic                       cfg_enable;
  logic [DIM_WIDTH-1:0]       cfg_rows;
  logic [DIM_WIDTH-1:0]       cfg_cols;

  logic                       enable;
  logic [DIM_WIDTH-1:0]       num_output_rows;
  logic [DIM_WIDTH-1:0]       num_output_cols;
  logic                       cfg_pending;
  logic                       cfg_ack;
  logic                       busy;
  logic [DIM_WIDTH-1:0]       meas_rows;
  logic [DIM_WIDTH-1:0]       meas_cols;
  logic [FRAME_CNT_WIDTH-1:0] frame_count;
  logic                       frame_err;
  logic                       clamped;

  modport master (
    output dvi, dtypei, cfg_req, cfg_enable, cfg_rows, cfg_cols,
    input  enable, num_output_rows, num_output_cols, cfg_pending, cfg_ack,
           busy, meas_rows, meas_cols, frame_count, frame_err, clamped
  );

  modport slave (
    input  dvi, dtypei, cfg_req, cfg_enable, cfg_rows, cfg_cols,
    output enable, num_output_rows, num_output_cols, cfg_pending, cfg_ack,
           busy, meas_rows, meas_cols, frame_count, frame_err, clamped
  );

endinterface

// File: rtl/crop_ctrl_frame_dim_meter.sv
// frame_dim_meter: saturating row/column counters for an image stream,
// latching the column count at each row end and the row count at frame end.
// Strobes are already qualified with dvi and framing state by the caller.
//   clk, resetb              : clock, async active-low reset
//   frame_start, frame_end   : frame boundary strobes (frame_end = valid end)
//   row_start, row_end, pixel: in-frame beat strobes
//   meas_rows, meas_cols     : registered dimensions of last row/frame
module frame_dim_meter #(
  parameter int unsigned DIM_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 row_start,
  input  logic                 row_end,
  input  logic                 pixel,
  output logic [DIM_WIDTH-1:0] meas_rows,
  output logic [DIM_WIDTH-1:0] meas_cols
);

  localparam logic [DIM_WIDTH-1:0] DIM_MAX = '1;

  logic [DIM_WIDTH-1:0] row_cnt;
  logic [DIM_WIDTH-1:0] col_cnt;

  // Counters and measurement latches.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      meas_rows <= '0;
      meas_cols <= '0;
    end else begin
      if (frame_start) begin
        row_cnt <= '0;
      end else if (row_end && (row_cnt != DIM_MAX)) begin
        row_cnt <= row_cnt + DIM_WIDTH'(1);
      end

      if (row_start) begin
        col_cnt <= '0;
      end else if (pixel && (col_cnt != DIM_MAX)) begin
        col_cnt <= col_cnt + DIM_WIDTH'(1);
      end

      if (row_end) begin
        meas_cols <= col_cnt;
      end
      if (frame_end) begin
        meas_rows <= row_cnt;
      end
    end
  end

endmodule

// File: rtl/crop_ctrl.sv
// crop_ctrl: frame-synchronous configuration controller for the crop stage.
// Register-side crop requests are held in a shadow and only become active on
// the cycle that samples FRAME_START, so no frame sees mixed settings. Also
// reports measured frame dimensions, frame count and a sticky framing error.
//   clk, resetb : image clock, async active-low reset
//   bus (slave) : dvi/dtypei stream, cfg_* request, active config + status
// Optional build macro CROP_CTRL_CLAMP_EN: clamp applied dims to the last
// measured (nonzero) frame dimensions and report it on clamped.
module crop_ctrl
  import crop_ctrl_pkg::*;
#(
  parameter int unsigned DIM_WIDTH       = 12,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       resetb,
  crop_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FRAME = 1'b1;

  logic [0:0] state_q, state_d;

  logic                       enable_q, enable_d;
  logic [DIM_WIDTH-1:0]       rows_q, rows_d;
  logic [DIM_WIDTH-1:0]       cols_q, cols_d;
  logic                       sh_en_q, sh_en_d;
  logic [DIM_WIDTH-1:0]       sh_rows_q, sh_rows_d;
  logic [DIM_WIDTH-1:0]       sh_cols_q, sh_cols_d;
  logic                       pending_q, pending_d;
  logic                       ack_q, ack_d;
  logic                       busy_q, busy_d;
  logic [FRAME_CNT_WIDTH-1:0] count_q, count_d;
  logic                       err_q, err_d;
  logic                       clamped_q, clamped_d;
  logic                       do_apply;

  logic [DIM_WIDTH-1:0] meas_rows, meas_cols;

  // Decoded, valid-qualified beats.
  logic fs, fe, rs, re, px, in_frame;
  assign fs       = bus.dvi && (bus.dtypei == DTYPE_FRAME_START);
  assign fe       = bus.dvi && (bus.dtypei == DTYPE_FRAME_END);
  assign rs       = bus.dvi && (bus.dtypei == DTYPE_ROW_START);
  assign re       = bus.dvi && (bus.dtypei == DTYPE_ROW_END);
  assign px       = bus.dvi && is_pixel(bus.dtypei);
  assign in_frame = (state_q == S_FRAME);

  frame_dim_meter #(.DIM_WIDTH(DIM_WIDTH)) u_meter (
    .clk         (clk),
    .resetb      (resetb),
    .frame_start (fs),
    .frame_end   (fe && in_frame),
    .row_start   (rs && in_frame),
    .row_end     (re && in_frame),
    .pixel       (px && in_frame),
    .meas_rows   (meas_rows),
    .meas_cols   (meas_cols)
  );

  // Config source on apply: a same-cycle request overrides the shadow.
  logic                 src_en;
  logic [DIM_WIDTH-1:0] src_rows, src_cols, fit_rows, fit_cols;
  logic                 clamp_hit;
  assign src_en   = bus.cfg_req ? bus.cfg_enable : sh_en_q;
  assign src_rows = bus.cfg_req ? bus.cfg_rows   : sh_rows_q;
  assign src_cols = bus.cfg_req ? bus.cfg_cols   : sh_cols_q;

`ifdef CROP_CTRL_CLAMP_EN
  // A zero measurement means nothing measured yet on that dim: no clamp.
  logic clamp_rows, clamp_cols;
  assign clamp_rows = (meas_rows != '0) && (src_rows > meas_rows);
  assign clamp_cols = (meas_cols != '0) && (src_cols > meas_cols);
  assign fit_rows   = clamp_rows ? meas_rows : src_rows;
  assign fit_cols   = clamp_cols ? meas_cols : src_cols;
  assign clamp_hit  = clamp_rows || clamp_cols;
`else
  assign fit_rows  = src_rows;
  assign fit_cols  = src_cols;
  assign clamp_hit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      sh_en_q   <= 1'b0;
      sh_rows_q <= '0;
      sh_cols_q <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      sh_en_q   <= sh_en_d;
      sh_rows_q <= sh_rows_d;
      sh_cols_q <= sh_cols_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      err_q     <= err_d;
      clamped_q <= clamped_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    sh_en_d   = sh_en_q;
    sh_rows_d = sh_rows_q;
    sh_cols_d = sh_cols_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    count_d   = count_q;
    err_d     = err_q;
    clamped_d = clamped_q;
    do_apply  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fs) begin
          state_d  = S_FRAME;
          busy_d   = 1'b1;
          do_apply = 1'b1;
        end else if (fe || rs || re || px) begin
          err_d = 1'b1;
        end
      end
      S_FRAME: begin
        if (fe) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          count_d = count_q + FRAME_CNT_WIDTH'(1);
        end else if (fs) begin
          // Missing FRAME_END: restart as a fresh frame, flag the error.
          err_d    = 1'b1;
          do_apply = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (do_apply) begin
      if (bus.cfg_req || pending_q) begin
        enable_d  = src_en;
        rows_d    = fit_rows;
        cols_d    = fit_cols;
        clamped_d = clamp_hit;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
    end else if (bus.cfg_req) begin
      sh_en_d   = bus.cfg_enable;
      sh_rows_d = bus.cfg_rows;
      sh_cols_d = bus.cfg_cols;
      pending_d = 1'b1;
    end
  end

  assign bus.enable          = enable_q;
  assign bus.num_output_rows = rows_q;
  assign bus.num_output_cols = cols_q;
  assign bus.cfg_pending     = pending_q;
  assign bus.cfg_ack         = ack_q;
  assign bus.busy            = busy_q;
  assign bus.meas_rows       = meas_rows;
  assign bus.meas_cols       = meas_cols;
  assign bus.frame_count     = count_q;
  assign bus.frame_err       = err_q;
  assign bus.clamped         = clamped_q;

endmodule

// File: tb/tb_crop_ctrl.sv
// tb_crop_ctrl: directed stimulus for crop_ctrl. Expected output values are
// queued as each step is driven and compared once the step's edge has passed.
module tb_crop_ctrl;
  import crop_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  crop_ctrl_if #(.DIM_WIDTH(12), .FRAME_CNT_WIDTH(16)) bus ();

  crop_ctrl #(.DIM_WIDTH(12), .FRAME_CNT_WIDTH(16)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  typedef enum int {F_EN, F_ROWS, F_COLS, F_PEND, F_ACK, F_BUSY,
                    F_MROWS, F_MCOLS, F_FCNT, F_ERR, F_CLAMP} fld_t;
  typedef struct {
    string       tag;
    fld_t        fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(input fld_t f);
    case (f)
      F_EN:    return 32'(bus.enable);
      F_ROWS:  return 32'(bus.num_output_rows);
      F_COLS:  return 32'(bus.num_output_cols);
      F_PEND:  return 32'(bus.cfg_pending);
      F_ACK:   return 32'(bus.cfg_ack);
      F_BUSY:  return 32'(bus.busy);
      F_MROWS: return 32'(bus.meas_rows);
      F_MCOLS: return 32'(bus.meas_cols);
      F_FCNT:  return 32'(bus.frame_count);
      F_ERR:   return 32'(bus.frame_err);
      default: return 32'(bus.clamped);
    endcase
  endfunction

  task automatic expv(input string tag, input fld_t f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.fld);
      n_cmp++;
      assert (o === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic expect_reset_state(input string tag);
    expv({tag, ".enable"}, F_EN, 0);
    expv({tag, ".rows"}, F_ROWS, 0);
    expv({tag, ".cols"}, F_COLS, 0);
    expv({tag, ".pending"}, F_PEND, 0);
    expv({tag, ".ack"}, F_ACK, 0);
    expv({tag, ".busy"}, F_BUSY, 0);
    expv({tag, ".meas_rows"}, F_MROWS, 0);
    expv({tag, ".meas_cols"}, F_MCOLS, 0);
    expv({tag, ".frame_count"}, F_FCNT, 0);
    expv({tag, ".frame_err"}, F_ERR, 0);
    expv({tag, ".clamped"}, F_CLAMP, 0);
  endtask

  // One clock of stimulus; outputs are stable 1 ns after the edge.
  task automatic drive(input logic v, input logic [DTYPE_WIDTH-1:0] dt,
                       input logic req, input logic en,
                       input logic [11:0] r, input logic [11:0] c);
    bus.dvi        = v;
    bus.dtypei     = dt;
    bus.cfg_req    = req;
    bus.cfg_enable = en;
    bus.cfg_rows   = r;
    bus.cfg_cols   = c;
    @(posedge clk);
    #1;
    bus.dvi     = 1'b0;
    bus.dtypei  = '0;
    bus.cfg_req = 1'b0;
  endtask

  task automatic beat(input logic [DTYPE_WIDTH-1:0] dt);
    drive(1'b1, dt, 1'b0, 1'b0, 12'd0, 12'd0);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 12'd0, 12'd0);
  endtask

  task automatic row(input int npix);
    beat(DTYPE_ROW_START);
    for (int i = 0; i < npix; i++) beat(DTYPE_PIXEL_MONO);
    beat(DTYPE_ROW_END);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetb         = 1'b0;
    bus.dvi        = 1'b0;
    bus.dtypei     = '0;
    bus.cfg_req    = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.cfg_rows   = '0;
    bus.cfg_cols   = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_reset_state("reset");
    drain();
    @(negedge clk);
    resetb = 1'b1;
    idle();

    // Request while idle: shadowed only.
    drive(1'b0, '0, 1'b1, 1'b1, 12'd4, 12'd6);
    expv("idle_req.pending", F_PEND, 1);
    expv("idle_req.enable", F_EN, 0);
    expv("idle_req.rows", F_ROWS, 0);
    expv("idle_req.cols", F_COLS, 0);
    expv("idle_req.ack", F_ACK, 0);
    drain();

    // Frame start applies the shadow.
    beat(DTYPE_FRAME_START);
    expv("fs1.ack", F_ACK, 1);
    expv("fs1.enable", F_EN, 1);
    expv("fs1.rows", F_ROWS, 4);
    expv("fs1.cols", F_COLS, 6);
    expv("fs1.pending", F_PEND, 0);
    expv("fs1.busy", F_BUSY, 1);
    drain();
    idle();
    expv("fs1.ack_drop", F_ACK, 0);
    drain();

    // 8x10 frame with a mid-frame request.
    row(10);
    expv("row1.meas_cols", F_MCOLS, 10);
    drain();
    drive(1'b0, '0, 1'b1, 1'b1, 12'd2, 12'd6);
    expv("mid_req.pending", F_PEND, 1);
    expv("mid_req.rows_hold", F_ROWS, 4);
    drain();
    for (int i = 0; i < 7; i++) row(10);
    beat(DTYPE_FRAME_END);
    expv("fe1.meas_rows", F_MROWS, 8);
    expv("fe1.meas_cols", F_MCOLS, 10);
    expv("fe1.frame_count", F_FCNT, 1);
    expv("fe1.busy", F_BUSY, 0);
    expv("fe1.frame_err", F_ERR, 0);
    expv("fe1.rows_hold", F_ROWS, 4);
    drain();
    idle();

    // Next frame picks up rows=2.
    beat(DTYPE_FRAME_START);
    expv("fs2.rows", F_ROWS, 2);
    expv("fs2.ack", F_ACK, 1);
    expv("fs2.pending", F_PEND, 0);
    expv("fs2.busy", F_BUSY, 1);
    drain();
    for (int i = 0; i < 3; i++) row(5);
    expv("short.meas_cols", F_MCOLS, 5);
    drain();
    drive(1'b0, '0, 1'b1, 1'b0, 12'd3, 12'd6);
    expv("req2.pending", F_PEND, 1);
    expv("req2.enable_hold", F_EN, 1);
    drain();

    // Second FRAME_START without FRAME_END.
    beat(DTYPE_FRAME_START);
    expv("refs.frame_err", F_ERR, 1);
    expv("refs.frame_count", F_FCNT, 1);
    expv("refs.meas_rows", F_MROWS, 8);
    expv("refs.enable", F_EN, 0);
    expv("refs.rows", F_ROWS, 3);
    expv("refs.cols", F_COLS, 6);
    expv("refs.ack", F_ACK, 1);
    expv("refs.pending", F_PEND, 0);
    expv("refs.busy", F_BUSY, 1);
    drain();
    for (int i = 0; i < 8; i++) row(10);
    beat(DTYPE_FRAME_END);
    expv("fe2.meas_rows", F_MROWS, 8);
    expv("fe2.meas_cols", F_MCOLS, 10);
    expv("fe2.frame_count", F_FCNT, 2);
    expv("fe2.frame_err_sticky", F_ERR, 1);
    drain();
    idle();

    // Request in the same cycle as FRAME_START; clamps when enabled.
    drive(1'b1, DTYPE_FRAME_START, 1'b1, 1'b1, 12'd20, 12'd6);
`ifdef CROP_CTRL_CLAMP_EN
    expv("same.rows", F_ROWS, 8);
    expv("same.clamped", F_CLAMP, 1);
`else
    expv("same.rows", F_ROWS, 20);
    expv("same.clamped", F_CLAMP, 0);
`endif
    expv("same.cols", F_COLS, 6);
    expv("same.enable", F_EN, 1);
    expv("same.ack", F_ACK, 1);
    expv("same.pending", F_PEND, 0);
    drain();
    idle();
    expv("same.ack_drop", F_ACK, 0);
    expv("same.pending_low", F_PEND, 0);
    drain();

    // Reset asserted mid-frame returns everything to reset values.
    row(3);
    #2;
    resetb = 1'b0;
    #1;
    expect_reset_state("midrst");
    drain();
    @(negedge clk);
    resetb = 1'b1;
    idle();

    // Stray beats while idle are ignored but flag the error.
    beat(DTYPE_ROW_END);
    expv("stray.frame_err", F_ERR, 1);
    expv("stray.meas_cols", F_MCOLS, 0);
    expv("stray.busy", F_BUSY, 0);
    drain();
    beat(DTYPE_PIXEL_MONO);

    // Resynchronise at the next frame.
    beat(DTYPE_FRAME_START);
    expv("resync.ack_none", F_ACK, 0);
    expv("resync.busy", F_BUSY, 1);
    drain();
    row(4);
    beat(DTYPE_FRAME_END);
    expv("resync.meas_cols", F_MCOLS, 4);
    expv("resync.meas_rows", F_MROWS, 1);
    expv("resync.frame_count", F_FCNT, 1);
    expv("resync.busy", F_BUSY, 0);
    drain();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
